// File: rtl/seg7_pkg.sv
// Shared types and pattern table for the 7-segment readers/decoders (abcdefg, a = bit 6).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t Seg0     = 7'b1111110;
  localparam seg_t Seg1     = 7'b0110000;
  localparam seg_t Seg2     = 7'b1101101;
  localparam seg_t Seg3     = 7'b1111001;
  localparam seg_t Seg4     = 7'b0110011;
  localparam seg_t Seg5     = 7'b1011011;
  localparam seg_t Seg6     = 7'b1011111;
  localparam seg_t Seg7     = 7'b1110000;
  localparam seg_t Seg8     = 7'b1111111;
  localparam seg_t Seg9     = 7'b1111011;
  localparam seg_t SegA     = 7'b1110111;
  localparam seg_t SegB     = 7'b0011111;
  localparam seg_t SegC     = 7'b1001110;
  localparam seg_t SegD     = 7'b0111101;
  localparam seg_t SegE     = 7'b1001111;
  localparam seg_t SegF     = 7'b1000111;
  localparam seg_t SegBlank = 7'b0000000;

  typedef enum logic [1:0] {
    StTrack,
    StCommit,
    StHold
  } state_e;

  // Returns {hit, nibble}; nibble is 0 when the pattern is not a hex glyph.
  function automatic logic [4:0] seg_to_nibble(seg_t seg);
    logic [4:0] res;
    case (seg)
      Seg0:    res = {1'b1, 4'h0};
      Seg1:    res = {1'b1, 4'h1};
      Seg2:    res = {1'b1, 4'h2};
      Seg3:    res = {1'b1, 4'h3};
      Seg4:    res = {1'b1, 4'h4};
      Seg5:    res = {1'b1, 4'h5};
      Seg6:    res = {1'b1, 4'h6};
      Seg7:    res = {1'b1, 4'h7};
      Seg8:    res = {1'b1, 4'h8};
      Seg9:    res = {1'b1, 4'h9};
      SegA:    res = {1'b1, 4'hA};
      SegB:    res = {1'b1, 4'hB};
      SegC:    res = {1'b1, 4'hC};
      SegD:    res = {1'b1, 4'hD};
      SegE:    res = {1'b1, 4'hE};
      SegF:    res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_pattern_encoder.sv
// Combinational classifier: active-high segment pattern to {hit, blank, nibble}.
module seg7_pattern_encoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic       blank_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    {hit_o, nibble_o} = seg_to_nibble(seg_i);
    blank_o           = (seg_i == SegBlank);
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed 7-segment bus into per-digit hex nibbles with glitch filtering.
// Optional decimal-point capture when SEG7_SCAN_READER_DP_EN is defined.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef SEG7_SCAN_READER_DP_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    err_pat,
  output logic                    frame_done
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  seg_t                  seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] dig_s1_q, dig_s2_q;
  logic [NUM_DIGITS-1:0] seen_q;
  logic [CntW-1:0]       cnt_q;
  state_e                state_q;
`ifdef SEG7_SCAN_READER_DP_EN
  logic                  dp_s1_q, dp_s2_q;
`endif

  logic                  same;
  logic                  commit;
  logic [NUM_DIGITS-1:0] seen_set;
  logic                  enc_hit;
  logic                  enc_blank;
  logic [3:0]            enc_nibble;

  seg7_pattern_encoder u_encoder (
    .seg_i    (seg_s2_q),
    .hit_o    (enc_hit),
    .blank_o  (enc_blank),
    .nibble_o (enc_nibble)
  );

  always_comb begin
    same = (seg_s1_q == seg_s2_q) && (dig_s1_q == dig_s2_q);
`ifdef SEG7_SCAN_READER_DP_EN
    same = same && (dp_s1_q == dp_s2_q);
`endif
    // s2 holds the sample that the saturated counter has vouched for.
    commit   = (state_q == StTrack) && (cnt_q == CntMax) && $onehot(dig_s2_q);
    seen_set = seen_q | dig_s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q    <= '0;
      seg_s2_q    <= '0;
      dig_s1_q    <= '0;
      dig_s2_q    <= '0;
      seen_q      <= '0;
      cnt_q       <= '0;
      state_q     <= StTrack;
      value_out   <= '0;
      digit_valid <= '0;
      err_pat     <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SEG7_SCAN_READER_DP_EN
      dp_s1_q     <= 1'b0;
      dp_s2_q     <= 1'b0;
      dp_out      <= '0;
`endif
    end else begin
      seg_s1_q   <= SEG_ACTIVE_LOW ? ~seg_in : seg_in;
      seg_s2_q   <= seg_s1_q;
      dig_s1_q   <= dig_sel;
      dig_s2_q   <= dig_s1_q;
`ifdef SEG7_SCAN_READER_DP_EN
      dp_s1_q    <= dp_in;
      dp_s2_q    <= dp_s1_q;
`endif
      err_pat    <= 1'b0;
      frame_done <= 1'b0;

      if (!same) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      unique case (state_q)
        StTrack:  if (commit) state_q <= StCommit;
        StCommit: state_q <= StHold;
        // An unsaturated counter means the sample moved during COMMIT.
        StHold:   if (!same || cnt_q != CntMax) state_q <= StTrack;
        default:  state_q <= StTrack;
      endcase

      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (dig_s2_q[i]) begin
            if (enc_hit) value_out[4*i +: 4] <= enc_nibble;
            digit_valid[i] <= enc_hit;
`ifdef SEG7_SCAN_READER_DP_EN
            dp_out[i]      <= dp_s2_q;
`endif
          end
        end
        err_pat <= !enc_hit && !enc_blank;
        if (&seen_set) begin
          frame_done <= 1'b1;
          seen_q     <= '0;
        end else begin
          seen_q     <= seen_set;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed, table-driven bench for seg7_scan_reader (4 digits, 4-sample filter).
module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic        err_pat;
  logic        frame_done;
`ifdef SEG7_SCAN_READER_DP_EN
  logic        dp_in;
  logic [3:0]  dp_out;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_reader #(
    .NUM_DIGITS     (4),
    .STABLE_CYCLES  (4),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
`ifdef SEG7_SCAN_READER_DP_EN
    .dp_in       (dp_in),
    .dp_out      (dp_out),
`endif
    .value_out   (value_out),
    .digit_valid (digit_valid),
    .err_pat     (err_pat),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [3:0]  dig;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] exp_value;
    logic [3:0]  exp_valid;
    int          exp_err;
    int          exp_frame;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s);
    dig_sel = d;
    seg_in  = s;
  endtask

  initial begin
    int err_cnt;
    int frame_cnt;
    int bad;
    int saw8;

    vecs[0]  = '{4'b0001, 7'b0110000, 6, 16'h0001, 4'b0001, 0, 0};
    vecs[1]  = '{4'b0010, 7'b1101101, 6, 16'h0021, 4'b0011, 0, 0};
    vecs[2]  = '{4'b0100, 7'b1110111, 6, 16'h0A21, 4'b0111, 0, 0};
    vecs[3]  = '{4'b1000, 7'b1000111, 6, 16'hFA21, 4'b1111, 0, 1};
    vecs[4]  = '{4'b0001, 7'b1111110, 6, 16'hFA20, 4'b1111, 0, 0};
    vecs[5]  = '{4'b0010, 7'b1111001, 6, 16'hFA30, 4'b1111, 0, 0};
    vecs[6]  = '{4'b0100, 7'b0110011, 6, 16'hF430, 4'b1111, 0, 0};
    vecs[7]  = '{4'b1000, 7'b1011011, 6, 16'h5430, 4'b1111, 0, 1};
    vecs[8]  = '{4'b0001, 7'b1011111, 6, 16'h5436, 4'b1111, 0, 0};
    vecs[9]  = '{4'b0010, 7'b1110000, 6, 16'h5476, 4'b1111, 0, 0};
    vecs[10] = '{4'b0100, 7'b1111111, 6, 16'h5876, 4'b1111, 0, 0};
    vecs[11] = '{4'b1000, 7'b1111011, 6, 16'h9876, 4'b1111, 0, 1};
    vecs[12] = '{4'b0001, 7'b0011111, 6, 16'h987B, 4'b1111, 0, 0};
    vecs[13] = '{4'b0010, 7'b1001110, 6, 16'h98CB, 4'b1111, 0, 0};
    vecs[14] = '{4'b0100, 7'b0111101, 6, 16'h9DCB, 4'b1111, 0, 0};
    vecs[15] = '{4'b1000, 7'b1001111, 6, 16'hEDCB, 4'b1111, 0, 1};
    vecs[16] = '{4'b1000, 7'b0000000, 6, 16'hEDCB, 4'b0111, 0, 0};
    vecs[17] = '{4'b0010, 7'b1000001, 10, 16'hEDCB, 4'b0101, 1, 0};
    vecs[18] = '{4'b0001, 7'b1111111, 6, 16'hEDC8, 4'b0101, 0, 0};
    vecs[19] = '{4'b0100, 7'b0000000, 6, 16'hEDC8, 4'b0001, 0, 1};

    rst = 1'b1;
    drive(4'b0000, 7'b0000000);
`ifdef SEG7_SCAN_READER_DP_EN
    dp_in = 1'b0;
`endif
    repeat (2) tick();
    check("reset_value", value_out, 0);
    check("reset_valid", digit_valid, 0);
    check("reset_err", err_pat, 0);
    check("reset_frame", frame_done, 0);
`ifdef SEG7_SCAN_READER_DP_EN
    check("reset_dp", dp_out, 0);
`endif
    rst = 1'b0;

    // Latency: sample first registered on edge 1, outputs move on edge 6.
    drive(4'b0001, 7'b1111001);
    err_cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (err_pat) err_cnt++;
      if (e == 5) check("lat_edge5_valid", digit_valid, 4'b0000);
    end
    check("lat_edge6_valid", digit_valid, 4'b0001);
    check("lat_edge6_nibble", value_out[3:0], 4'h3);
    check("lat_err", err_cnt, 0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].dig, vecs[i].seg);
      err_cnt   = 0;
      frame_cnt = 0;
      for (int c = 0; c < vecs[i].hold; c++) begin
        tick();
        if (err_pat) err_cnt++;
        if (frame_done) frame_cnt++;
      end
      check($sformatf("row%0d_value", i), value_out, vecs[i].exp_value);
      check($sformatf("row%0d_valid", i), digit_valid, vecs[i].exp_valid);
      check($sformatf("row%0d_err", i), err_cnt, vecs[i].exp_err);
      check($sformatf("row%0d_frame", i), frame_cnt, vecs[i].exp_frame);
    end

    // Glitch filtering on digit 2.
    drive(4'b0100, 7'b1110000);
    repeat (6) tick();
    check("glitch_pre_value", value_out, 16'hE7C8);
    check("glitch_pre_valid", digit_valid, 4'b0101);
    bad = 0;
    drive(4'b0100, 7'b1111111);
    repeat (2) begin
      tick();
      if (value_out[11:8] !== 4'h7) bad++;
    end
    drive(4'b0100, 7'b1110000);
    repeat (8) begin
      tick();
      if (value_out[11:8] !== 4'h7) bad++;
    end
    check("glitch2_no_commit", bad, 0);

    // A blip as long as the filter window is a real pattern and must commit.
    saw8 = 0;
    drive(4'b0100, 7'b1111111);
    repeat (4) begin
      tick();
      if (value_out[11:8] === 4'h8) saw8 = 1;
    end
    drive(4'b0100, 7'b1110000);
    repeat (8) begin
      tick();
      if (value_out[11:8] === 4'h8) saw8 = 1;
    end
    check("glitch4_commits", saw8, 1);
    check("glitch4_recommit", value_out[11:8], 4'h7);

    // Multi-hot select never commits.
    bad = 0;
    drive(4'b0011, 7'b1111110);
    repeat (20) begin
      tick();
      if (value_out !== 16'hE7C8 || digit_valid !== 4'b0101 || err_pat || frame_done) bad++;
    end
    check("multihot_no_change", bad, 0);
    rst = 1'b1;
    tick();
    check("midrst_value", value_out, 0);
    check("midrst_valid", digit_valid, 0);
    check("midrst_err", err_pat, 0);
    rst = 1'b0;

    // Reset landing on the would-be commit edge suppresses the commit.
    drive(4'b0001, 7'b1111011);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstcommit_valid", digit_valid, 0);
    check("rstcommit_value", value_out, 0);
    tick();
    check("rstcommit_after_valid", digit_valid, 0);
    repeat (6) tick();
    check("recover_valid", digit_valid, 4'b0001);
    check("recover_value", value_out, 16'h0009);

`ifdef SEG7_SCAN_READER_DP_EN
    drive(4'b0001, 7'b1011011);
    dp_in = 1'b1;
    repeat (6) tick();
    check("dp_set", dp_out, 4'b0001);
    check("dp_nibble", value_out[3:0], 4'h5);
    dp_in = 1'b0;
    repeat (8) tick();
    check("dp_clear", dp_out, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
